// File: rtl/sram_controller.sv
// sram_controller
// Multi-cycle access controller between the MEM pipeline stage and a 16-bit
// asynchronous SRAM. Each 32-bit read or write becomes two half-word phases,
// LOW then HIGH. Each phase lasts WAIT_CYCLES cycles. The request is latched
// when it is accepted, so the pipeline may change its inputs while the
// access is in flight.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   rd_en, wr_en    read / write request (write wins when both are high)
//   address         CPU byte address; BASE_ADDR maps to SRAM word 0
//   write_data      store data
//   read_data       last completed read word
//   ready           high when idle with no request, or in the DONE cycle
//   SRAM_*          external SRAM pins; CE/UB/LB are tied active

module sram_controller #(
    parameter int unsigned BASE_ADDR       = 1024,
    parameter int unsigned WAIT_CYCLES     = 2,
    parameter int unsigned SRAM_ADDR_WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic                       wr_en,
    input  logic [31:0]                address,
    input  logic [31:0]                write_data,
    output logic [31:0]                read_data,
    output logic                       ready,
    inout  wire  [15:0]                SRAM_DQ,
    output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
    output logic                       SRAM_WE_N,
    output logic                       SRAM_OE_N,
    output logic                       SRAM_CE_N,
    output logic                       SRAM_UB_N,
    output logic                       SRAM_LB_N
);

    localparam int unsigned AW       = SRAM_ADDR_WIDTH;
    localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic [3:0]      cnt_r;
    logic            op_write_r;
    logic [31:0]     wdata_r;
    logic [AW-2:0]   word_r;
    logic [31:0]     read_data_r;
    logic [AW-1:0]   addr_r;
    logic            we_n_r;
    logic            oe_n_r;
    logic            dq_oe_r;
    logic [15:0]     dq_out_r;

    logic [31:0]     offs_s;
    logic [AW-2:0]   word_s;
    logic [3:0]      cnt_inc_s;
    logic            we_n_mid_s;
    logic            unused_bits_s;

    // Word index of the incoming request; the subtraction wraps mod 2^32
    assign offs_s        = address - 32'(BASE_ADDR);
    assign word_s        = offs_s[AW:2];
    assign unused_bits_s = ^{offs_s[31:AW+1], offs_s[1:0]};

    assign cnt_inc_s = cnt_r + 4'd1;
    // WE_N for the next cycle of a running phase. It goes high on the phase's
    // last cycle, so the SRAM latches the data before address and DQ move on.
    assign we_n_mid_s = !(op_write_r && (cnt_inc_s != CNT_LAST));

    // Pin drivers; the outputs come straight from registers
    assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'hzzzz;
    assign SRAM_ADDR = addr_r;
    assign SRAM_WE_N = we_n_r;
    assign SRAM_OE_N = oe_n_r;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign read_data = read_data_r;

    // Stall output, combinational so the pipeline freezes in the request cycle
    assign ready = ((state_r == IDLE) && !rd_en && !wr_en) || (state_r == DONE);

    // Access FSM; outputs are registered from the transition being taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            op_write_r  <= 1'b0;
            wdata_r     <= 32'd0;
            word_r      <= {(AW-1){1'b0}};
            read_data_r <= 32'd0;
            addr_r      <= {AW{1'b0}};
            we_n_r      <= 1'b1;
            oe_n_r      <= 1'b1;
            dq_oe_r     <= 1'b0;
            dq_out_r    <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        state_r    <= LOW;
                        cnt_r      <= 4'd0;
                        op_write_r <= wr_en;
                        wdata_r    <= write_data;
                        word_r     <= word_s;
                        addr_r     <= {word_s, 1'b0};
                        // WAIT_CYCLES >= 2, so the first phase cycle is never the last
                        we_n_r     <= !wr_en;
                        oe_n_r     <= wr_en;
                        dq_oe_r    <= wr_en;
                        dq_out_r   <= write_data[15:0];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOW: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r  <= HIGH;
                        cnt_r    <= 4'd0;
                        addr_r   <= {word_r, 1'b1};
                        we_n_r   <= !op_write_r;
                        dq_out_r <= wdata_r[31:16];
                        if (!op_write_r) begin
                            read_data_r[15:0] <= SRAM_DQ;
                        end else begin
                            read_data_r <= read_data_r;
                        end
                    end else begin
                        cnt_r  <= cnt_inc_s;
                        we_n_r <= we_n_mid_s;
                    end
                end
                HIGH: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r  <= DONE;
                        cnt_r    <= 4'd0;
                        addr_r   <= {AW{1'b0}};
                        we_n_r   <= 1'b1;
                        oe_n_r   <= 1'b1;
                        dq_oe_r  <= 1'b0;
                        dq_out_r <= 16'd0;
                        if (!op_write_r) begin
                            read_data_r[31:16] <= SRAM_DQ;
                        end else begin
                            read_data_r <= read_data_r;
                        end
                    end else begin
                        cnt_r  <= cnt_inc_s;
                        we_n_r <= we_n_mid_s;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= 4'd0;
                    addr_r   <= {AW{1'b0}};
                    we_n_r   <= 1'b1;
                    oe_n_r   <= 1'b1;
                    dq_oe_r  <= 1'b0;
                    dq_out_r <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller. A small asynchronous SRAM model sits on the pins.
// Expected read words are queued when each read is issued, and are popped and
// compared when the DUT raises ready in DONE.

module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    int          n_cmp;
    int          n_mis;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_rd;
    logic [15:0] mem [0:1023];

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: drives the bus on reads and takes write data while WE_N is low
    assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;
    always @(negedge clk) begin
        if (!sram_we_n && !sram_ce_n) mem[sram_addr[9:0]] = sram_dq;
    end

    // Global time limit
    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request, follows it to DONE and checks pins, stall length and result
    task automatic run_access(input string tag, input logic w, input logic r,
                              input logic [31:0] a, input logic [31:0] d, input int drop_at);
        logic [31:0] off;
        logic [17:0] exp_lo;
        logic [3:0]  we_seq;
        logic [31:0] exp_w;
        int          c;
        bit          done;
        off    = a - 32'd1024;
        exp_lo = {off[18:2], 1'b0};
        @(posedge clk);
        #1;
        rd_en = r; wr_en = w; address = a; write_data = d;
        if (w) ref_mem[a] = d;
        else exp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : 32'd0);
        c = 0; done = 1'b0; we_seq = 4'b0000;
        while (!done && c < 20) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
            end else begin
                if (c >= 1 && c <= 4) begin
                    we_seq = {we_seq[2:0], sram_we_n};
                    check_eq({tag, "_addr"}, 32'(sram_addr), 32'(exp_lo | ((c >= 3) ? 18'd1 : 18'd0)));
                    check_eq({tag, "_oe_n"}, 32'(sram_oe_n), w ? 32'd1 : 32'd0);
                    if (w) check_eq({tag, "_dq"}, 32'(sram_dq), (c >= 3) ? 32'(d[31:16]) : 32'(d[15:0]));
                end
                c++;
                if (c == drop_at) begin
                    @(posedge clk);
                    #1;
                    rd_en = 1'b0; wr_en = 1'b0;
                    address = 32'hFFFF_FFF0; write_data = 32'h0;
                end
            end
        end
        check_eq({tag, "_stall"}, 32'(c), 32'd5);
        if (w) begin
            check_eq({tag, "_we_seq"}, 32'(we_seq), 32'h5);
            check_eq({tag, "_rd_keep"}, read_data, last_rd);
            check_eq({tag, "_mem_lo"}, 32'(mem[exp_lo[9:0]]), 32'(d[15:0]));
            check_eq({tag, "_mem_hi"}, 32'(mem[exp_lo[9:0] + 10'd1]), 32'(d[31:16]));
        end else begin
            check_eq({tag, "_we_seq"}, 32'(we_seq), 32'hF);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                check_eq({tag, "_rdata"}, read_data, exp_w);
                last_rd = exp_w;
            end else begin
                check_eq({tag, "_q_empty"}, 32'd1, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check_eq({tag, "_idle_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; last_rd = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_rdata", read_data, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_ready", 32'(ready), 32'd1);
            check_eq("idle_pins", {sram_we_n, sram_oe_n, 12'd0, sram_addr}, {1'b1, 1'b1, 30'd0});
            check_eq("idle_rdata", read_data, 32'd0);
        end

        run_access("wr1028", 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 0);
        check_eq("wr1028_half2", 32'(mem[2]), 32'h0000BEEF);
        check_eq("wr1028_half3", 32'(mem[3]), 32'h0000DEAD);
        run_access("rd1028", 1'b0, 1'b1, 32'd1028, 32'd0, 0);
        check_eq("rd1028_const", read_data, 32'hDEADBEEF);

        run_access("both1024", 1'b1, 1'b1, 32'd1024, 32'h12345678, 0);
        check_eq("both_half0", 32'(mem[0]), 32'h00005678);
        check_eq("both_half1", 32'(mem[1]), 32'h00001234);
        check_eq("both_rdata", read_data, 32'hDEADBEEF);

        run_access("drop1032", 1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 2);
        run_access("rd1032", 1'b0, 1'b1, 32'd1032, 32'd0, 0);
        check_eq("rd1032_const", read_data, 32'hCAFEF00D);

        // Reset at cycle 3 of a read
        @(posedge clk);
        #1;
        rd_en = 1'b1; address = 32'd1024;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstmid_ready", 32'(ready), 32'd1);
        check_eq("rstmid_oe_n", 32'(sram_oe_n), 32'd1);
        check_eq("rstmid_we_n", 32'(sram_we_n), 32'd1);
        check_eq("rstmid_addr", 32'(sram_addr), 32'd0);
        check_eq("rstmid_rdata", read_data, 32'd0);
        last_rd = 32'd0;
        run_access("rd1028b", 1'b0, 1'b1, 32'd1028, 32'd0, 0);
        check_eq("rd1028b_const", read_data, 32'hDEADBEEF);

        // Address below BASE_ADDR wraps to the top of the SRAM
        run_access("wr1020", 1'b1, 1'b0, 32'd1020, 32'h0BADC0DE, 0);
        check_eq("wr1020_top", 32'(mem[10'h3FE]), 32'h0000C0DE);
        run_access("rd1020", 1'b0, 1'b1, 32'd1020, 32'd0, 0);

        // Random write/read pairs
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'd1024 + 32'($urandom_range(8, 63)) * 32'd4;
            d = $urandom;
            run_access("rnd_wr", 1'b1, 1'b0, a, d, 0);
            run_access("rnd_rd", 1'b0, 1'b1, a, 32'd0, 0);
            check_eq("rnd_data", read_data, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle access controller between the MEM pipeline stage and a 16-bit external asynchronous SRAM. It accepts the 32-bit `mem_read`/`mem_write` requests the control unit generates, sequences each one as two 16-bit half-word accesses, and holds `ready` low until the access completes. The hazard/freeze logic uses `ready` to stall every pipeline register. A read returns its 32-bit word on `read_data`.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, 2: cycles per half-word phase. Legal range is 2 to 15.
- `SRAM_ADDR_WIDTH`, 18: SRAM half-word address width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rd_en`  in  1  read request from the MEM stage (LDR).
- `wr_en`  in  1  write request from the MEM stage (STR).
- `address`  in  32  CPU byte address (ALU result).
- `write_data`  in  32  store data (Rm value).
- `read_data`  out  32  last completed read word.
- `ready`  out  1  high when no access is pending or the access completes this cycle.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  SRAM_ADDR_WIDTH  SRAM half-word address.
- `SRAM_WE_N`  out  1  write enable, active-low.
- `SRAM_OE_N`  out  1  output enable, active-low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  tied to 0.

## Operation
- **States:** IDLE, LOW, HIGH, DONE. A phase counter `cnt` counts from 0 to WAIT_CYCLES-1.
- **IDLE:**
  - If `wr_en` or `rd_en` is high, latch op = write when `wr_en` is high, otherwise read. Write has priority when both are high.
  - Latch `address` and `write_data`, clear `cnt`, and go to LOW.
  - Otherwise stay in IDLE.
- **Address mapping:** `word = (addr_latched - BASE_ADDR) >> 2`, computed mod 2^32 and truncated to SRAM_ADDR_WIDTH-1 bits.
  - LOW drives `SRAM_ADDR = {word,0}`.
  - HIGH drives `SRAM_ADDR = {word,1}`.
  - IDLE and DONE drive `SRAM_ADDR = 0`.
- **LOW/HIGH, each lasting WAIT_CYCLES cycles:**
  - `cnt` increments each cycle.
  - When `cnt == WAIT_CYCLES-1`: LOW goes to HIGH, HIGH goes to DONE, and `cnt` clears.
- **Read:**
  - `SRAM_OE_N` = 0 throughout LOW and HIGH, and `SRAM_DQ` is high-Z.
  - On the final cycle of LOW, `read_data[15:0] <= SRAM_DQ`.
  - On the final cycle of HIGH, `read_data[31:16] <= SRAM_DQ`.
- **Write:**
  - `SRAM_OE_N` = 1.
  - `SRAM_DQ` is driven with `wdata[15:0]` in LOW and `wdata[31:16]` in HIGH.
  - `SRAM_WE_N` = 0 on every cycle of a phase except its final cycle. WE_N rises one cycle before the address changes.
  - `read_data` is unchanged by writes.
- **DONE:** lasts one cycle, then goes to IDLE.
- **ready:** combinational, `ready = (state==IDLE && !rd_en && !wr_en) || state==DONE`.
- **Request changes after start:** once LOW is entered, the transaction runs to DONE using latched values. Dropping or changing `rd_en`, `wr_en`, `address` or `write_data` has no effect.
- **Reset:** `rst` is honoured in any state, including mid-transaction, and a partial write is abandoned. Values on the next edge:
  - state = IDLE, `cnt` = 0, `read_data` = 0.
  - `SRAM_WE_N` = 1, `SRAM_OE_N` = 1, `SRAM_ADDR` = 0, `SRAM_DQ` high-Z.
  - `ready` follows its equation, i.e. it is high if there is no request.

## Timing
- **Request to ready:** a request first seen at cycle 0 in IDLE gives `ready` = 0 at cycles 0 to 2·WAIT_CYCLES.
  - `ready` = 1 at cycle 2·WAIT_CYCLES+1 (DONE).
  - With WAIT_CYCLES = 2 this is 5 stall cycles, with ready high at cycle 5.
- **Read data valid:** `read_data` holds the new word from cycle 2·WAIT_CYCLES+1 (DONE) onward and stays stable until the next read's LOW capture.
- **Back-to-back:** the pipeline advances on the DONE edge, so the next instruction's request is seen in IDLE at cycle 2·WAIT_CYCLES+2. There is exactly one idle, not-ready cycle between transactions.
- **No request:** with no request, `ready` stays 1 continuously and the SRAM outputs stay at their reset values.

## Test plan
- **Reset/idle:** with `rst`=1 and then idle for 10 cycles, `ready`=1, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z and `read_data`=0 throughout.
- **Write then read:** write 0xDEADBEEF to address 1028, hold until ready, then read 1028.
  - Write phase: SRAM half-address 2 gets 0xBEEF and 3 gets 0xDEAD.
  - `ready` is low for exactly 5 cycles each time.
  - `read_data` = 0xDEADBEEF in DONE.
- **WE_N shape:** during the 1028 write with WAIT_CYCLES=2, `SRAM_WE_N` = 0,1,0,1 across the LOW/HIGH cycles, and DQ is stable while WE_N is low.
- **Simultaneous requests:** `rd_en`=`wr_en`=1 at address 1024 with data 0x12345678 performs a write. The SRAM model shows 0x5678/0x1234 at half-addresses 0/1, and `read_data` is unchanged.
- **Request dropped:** start a write to 1032 with 0xCAFEF00D, then drop `wr_en` at cycle 2. The transaction still completes, DONE occurs at cycle 5, and a later read of 1032 returns 0xCAFEF00D.
- **Reset mid-read:** assert `rst` at cycle 3 of a read.
  - The next cycle is IDLE with `SRAM_OE_N`=1 and `read_data`=0.
  - A subsequent read of 1028 completes normally and returns 0xDEADBEEF.
